// File: rtl/alu_pkg.sv
// ALU shared definitions: datapath width, opcode encodings, shifter direction.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  // Default datapath width
  localparam int XLEN = 32;

  // Opcode field width and type
  localparam int OP_W = 4;
  typedef logic [OP_W-1:0] alu_op_t;

  // Operation encodings; 4'b1011..4'b1111 are reserved and yield zero
  localparam alu_op_t ALU_AND    = 4'b0000;
  localparam alu_op_t ALU_OR     = 4'b0001;
  localparam alu_op_t ALU_XOR    = 4'b0010;
  localparam alu_op_t ALU_SLL    = 4'b0011;
  localparam alu_op_t ALU_ADD    = 4'b0100;
  localparam alu_op_t ALU_SRL    = 4'b0101;
  localparam alu_op_t ALU_SRA    = 4'b0110;
  localparam alu_op_t ALU_SUB    = 4'b0111;
  localparam alu_op_t ALU_SLT    = 4'b1000;
  localparam alu_op_t ALU_SLTU   = 4'b1001;
  localparam alu_op_t ALU_PASS_B = 4'b1010;

  // Shift amount field width (b[4:0])
  localparam int SHAMT_W = 5;

  // Shifter direction select
  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter: logical left, logical right, arithmetic right by 0..31.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module alu_shifter #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic [XLEN-1:0]             i_data,
  input  logic [alu_pkg::SHAMT_W-1:0] i_amount,
  input  logic                        i_dir,
  input  logic                        i_arith,
  output logic [XLEN-1:0]             o_result
);
  import alu_pkg::*;

  logic [XLEN-1:0] w_in;
  logic [XLEN-1:0] w_stage [0:SHAMT_W];
  logic            w_fill;

  // Vacated bits take the sign only for an arithmetic right shift
  assign w_fill = i_arith & (i_dir == SHIFT_RIGHT) & i_data[XLEN-1];

  // Mirror the operand for a left shift so the right-shift stages serve both
  always_comb begin
    w_in = i_data;
    if (i_dir == SHIFT_LEFT) begin
      for (int i = 0; i < XLEN; i++) begin
        w_in[i] = i_data[XLEN-1-i];
      end
    end
  end

  assign w_stage[0] = w_in;

  // Log-depth stages: stage k shifts right by 2**k when amount bit k is set
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign w_stage[k+1] = i_amount[k] ? {{SH{w_fill}}, w_stage[k][XLEN-1:SH]}
                                      : w_stage[k];
  end

  // Undo the mirror on the way out for a left shift
  always_comb begin
    o_result = w_stage[SHAMT_W];
    if (i_dir == SHIFT_LEFT) begin
      for (int i = 0; i < XLEN; i++) begin
        o_result[i] = w_stage[SHAMT_W][XLEN-1-i];
      end
    end
  end

endmodule

// File: rtl/alu_1.sv
// Integer ALU with combinational result/zero and a registered copy of the result.
// Latency: result/zero zero cycles; result_q one clk edge; reset clears result_q at once.
// Backpressure: none; a new op/operand set may be presented every cycle.
module alu_1 #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [alu_pkg::OP_W-1:0] alu_input_op,
  input  logic [XLEN-1:0]          alu_input_a,
  input  logic [XLEN-1:0]          alu_input_b,
  output logic [XLEN-1:0]          alu_output_result,
  output logic                     alu_output_zero,
  output logic [XLEN-1:0]          alu_output_result_q
);
  import alu_pkg::*;

  logic [XLEN-1:0] w_shift_res;
  logic            w_shift_dir;
  logic            w_shift_arith;
  logic            w_lt_signed;
  logic            w_lt_unsigned;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] r_result_q;

  assign w_shift_dir   = ((alu_input_op == ALU_SRL) || (alu_input_op == ALU_SRA))
                         ? SHIFT_RIGHT : SHIFT_LEFT;
  assign w_shift_arith = (alu_input_op == ALU_SRA);

  // Only b[4:0] reaches the shifter; the upper bits of b are ignored for shifts
  alu_shifter #(.XLEN(XLEN)) u_shifter (
    .i_data   (alu_input_a),
    .i_amount (alu_input_b[SHAMT_W-1:0]),
    .i_dir    (w_shift_dir),
    .i_arith  (w_shift_arith),
    .o_result (w_shift_res)
  );

  assign w_lt_signed   = ($signed(alu_input_a) < $signed(alu_input_b));
  assign w_lt_unsigned = (alu_input_a < alu_input_b);

  // Operation select; reserved encodings fall to the zero default
  always_comb begin
    w_result = '0;
    case (alu_input_op)
      ALU_AND:    w_result = alu_input_a & alu_input_b;
      ALU_OR:     w_result = alu_input_a | alu_input_b;
      ALU_XOR:    w_result = alu_input_a ^ alu_input_b;
      ALU_SLL:    w_result = w_shift_res;
      ALU_ADD:    w_result = alu_input_a + alu_input_b;
      ALU_SRL:    w_result = w_shift_res;
      ALU_SRA:    w_result = w_shift_res;
      ALU_SUB:    w_result = alu_input_a - alu_input_b;
      ALU_SLT:    w_result = {{(XLEN-1){1'b0}}, w_lt_signed};
      ALU_SLTU:   w_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
      ALU_PASS_B: w_result = alu_input_b;
      default:    w_result = '0;
    endcase
  end

  assign alu_output_result = w_result;
  assign alu_output_zero   = (w_result == '0);

  // Registered copy of the result; reset clears it without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result_q <= '0;
    end else begin
      r_result_q <= w_result;
    end
  end

  assign alu_output_result_q = r_result_q;

endmodule

// File: tb/tb_alu_1.sv
module tb_alu_1;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res;
  logic        zero;
  logic [31:0] res_q;

  int n_checks = 0;
  int n_fail   = 0;

  alu_1 #(.XLEN(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .alu_input_op        (op),
    .alu_input_a         (a),
    .alu_input_b         (b),
    .alu_output_result   (res),
    .alu_output_zero     (zero),
    .alu_output_result_q (res_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model computed from the arithmetic meaning of each operation
  function automatic logic [31:0] ref_alu(input logic [3:0] rop, input logic [31:0] ra,
                                          input logic [31:0] rb);
    longint unsigned ua;
    longint unsigned ub;
    longint          sa;
    longint          sb;
    longint unsigned p2;
    longint          p2s;
    int              sh;
    logic [31:0]     r;
    ua = ra;
    ub = rb;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    sh = int'(rb % 32);
    p2 = 1;
    for (int i = 0; i < sh; i++) p2 = p2 * 2;
    p2s = longint'(p2);
    case (int'(rop))
      0:  r = ra & rb;
      1:  r = ra | rb;
      2:  r = ra ^ rb;
      3:  r = 32'(ua * p2);
      4:  r = 32'(ua + ub);
      5:  r = 32'(ua / p2);
      6:  r = (sa >= 0) ? 32'(sa / p2s) : 32'(-((-sa + p2s - 1) / p2s));
      7:  r = 32'(ua - ub);
      8:  r = (sa < sb) ? 32'd1 : 32'd0;
      9:  r = (ua < ub) ? 32'd1 : 32'd0;
      10: r = rb;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Apply one operation mid-cycle, check the combinational outputs, then the register
  task automatic apply(input string name, input logic [3:0] vop, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] eres, input logic ezero);
    @(negedge clk);
    op = vop;
    a  = va;
    b  = vb;
    #1;
    check({name, ".res"}, res, eres);
    check({name, ".zero"}, {31'd0, zero}, {31'd0, ezero});
    @(posedge clk);
    #1;
    check({name, ".res_q"}, res_q, eres);
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] held;

    // Directed table
    vecs.push_back('{4'b0100, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0});
    vecs.push_back('{4'b0100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1});
    vecs.push_back('{4'b0111, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0});
    vecs.push_back('{4'b0110, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0});
    vecs.push_back('{4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0});
    vecs.push_back('{4'b0011, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0});
    vecs.push_back('{4'b0110, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0});
    vecs.push_back('{4'b0011, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0});
    vecs.push_back('{4'b0110, 32'h80000001, 32'h0000001F, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{4'b0101, 32'h80000001, 32'h0000001F, 32'h00000001, 1'b0});
    vecs.push_back('{4'b0011, 32'h00000003, 32'h0000001F, 32'h80000000, 1'b0});
    vecs.push_back('{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0});
    vecs.push_back('{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1});
    vecs.push_back('{4'b1000, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0});
    vecs.push_back('{4'b1001, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b1});
    vecs.push_back('{4'b1000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1});
    vecs.push_back('{4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0});
    vecs.push_back('{4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0});
    vecs.push_back('{4'b0010, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0});
    vecs.push_back('{4'b1010, 32'h00000001, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{4'b1111, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1});
    vecs.push_back('{4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1});

    // Reset state, and combinational path unaffected by reset
    reset = 1'b1;
    op = 4'b0100;
    a  = 32'd1;
    b  = 32'd1;
    #1;
    check("reset.res_q", res_q, 32'h0);
    check("reset.res", res, 32'h2);
    @(posedge clk);
    #1;
    check("reset.hold_q", res_q, 32'h0);
    check("reset.zero", {31'd0, zero}, 32'd0);

    // First edge after release loads the current combinational result
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release.pre_edge_q", res_q, 32'h0);
    @(posedge clk);
    #1;
    check("release.first_edge_q", res_q, 32'h2);

    foreach (vecs[i]) begin
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero);
    end

    // Mid-cycle operand change reaches only the combinational outputs
    apply("hold.setup", 4'b0100, 32'd10, 32'd20, 32'd30, 1'b0);
    @(negedge clk);
    op = 4'b0111;
    a  = 32'd5;
    b  = 32'd5;
    #1;
    check("hold.res", res, 32'h0);
    check("hold.zero", {31'd0, zero}, 32'd1);
    check("hold.res_q", res_q, 32'd30);
    @(posedge clk);
    #1;
    check("hold.after_edge_q", res_q, 32'h0);

    // Asynchronous reset asserted mid-cycle clears result_q at once
    apply("arst.setup", 4'b1010, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst.res_q", res_q, 32'h0);
    check("arst.res", res, 32'hA5A5A5A5);
    @(negedge clk);
    reset = 1'b0;
    op = 4'b0000;
    a  = 32'h0000F0F0;
    b  = 32'h0000FF00;
    #1;
    check("arst.pre_edge_q", res_q, 32'h0);
    @(posedge clk);
    #1;
    check("arst.post_edge_q", res_q, 32'h0000F000);

    // Randomized operations against the reference model
    held = res_q;
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = rb & 32'hFFFFFFE0;
        1: rb = rb | 32'h0000001F;
        2: rb = ra;
        3: ra = ra | 32'h80000000;
        default: ;
      endcase
      e = ref_alu(rop, ra, rb);
      apply($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, e, (e == 32'd0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_1.md
ALU_1 -- requirements
Module: alu_1

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; the function requirements below hold for XLEN=32.
REQ-002 Port: clk  input  1  single clock; clocks the result register only.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: alu_input_op  input  4  operation select, encoding per REQ-008.
REQ-005 Port: alu_input_a  input  32  operand A.
REQ-006 Port: alu_input_b  input  32  operand B; bits [4:0] are the shift amount for shift operations.
REQ-007 Outputs:
- alu_output_result  output  32  combinational result.
- alu_output_zero  output  1  combinational; 1 when alu_output_result == 0.
- alu_output_result_q  output  32  alu_output_result registered on the clk rising edge.

Function
REQ-008 Op encoding:
- 0000 AND
- 0001 OR
- 0010 XOR
- 0011 SLL
- 0100 ADD
- 0101 SRL
- 0110 SRA
- 0111 SUB
- 1000 SLT (signed)
- 1001 SLTU (unsigned)
- 1010 PASS_B
- 1011..1111 reserved
REQ-009 alu_output_result SHALL be purely combinational from op/a/b: zero cycle latency, no dependence on clk or reset.
REQ-010 ADD/SUB SHALL be modulo 2^32; carry and overflow are discarded, with no saturation.
REQ-011 SLL/SRL SHALL shift A by b[4:0] and fill with zeros; SRA SHALL fill with A[31]; b[31:5] are ignored.
REQ-012 SLT/SLTU SHALL output 32'h1 when A<B (signed or unsigned respectively), else 32'h0.
REQ-013 PASS_B SHALL output B unchanged.
REQ-014 Reserved opcodes SHALL output 32'h0 and SHALL NOT produce X.
REQ-015 Shift amount 0 SHALL return A unchanged; shift amount 31 SHALL be fully supported.
REQ-016 alu_output_result_q SHALL capture alu_output_result on every rising clk edge while reset is low, giving one cycle of latency.
REQ-017 An op/operand change mid-cycle SHALL affect only alu_output_result and alu_output_zero until the next clk edge.

Reset
REQ-018 While reset is high, alu_output_result_q SHALL be 32'h0 immediately, without waiting for a clk edge.
REQ-019 Reset SHALL NOT affect alu_output_result or alu_output_zero.
REQ-020 On reset release, the first rising clk edge SHALL load the current combinational result.

Structure
REQ-021 Package alu_pkg SHALL hold the 4-bit op localparams (ALU_AND ... ALU_PASS_B) and XLEN.
REQ-022 The shifter SHALL be a sub-module alu_shifter (inputs: data, amount[4:0], dir, arith); everything else SHALL be inline.
REQ-023 There SHALL be no latches, and every case SHALL have a default.

Verification
REQ-024 op=0100, a=1, b=1 -> result 32'h2 within 100 time units, zero=0.
REQ-025 op=0100, a=32'hFFFFFFFF, b=1 -> result 0, zero=1; op=0111, a=0, b=1 -> 32'hFFFFFFFF.
REQ-026 op=0110, a=32'h80000000, b=4 -> 32'hF8000000; op=0101, same a/b -> 32'h08000000; op=0011, a=1, b=32'h3F -> 32'h80000000.
REQ-027 op=1000, a=32'hFFFFFFFF, b=1 -> 1; op=1001, same a/b -> 0; op=1111 -> 0.
REQ-028 Assert reset asynchronously mid-cycle -> result_q=0 at once; release, apply op=0000, a=32'hF0F0, b=32'hFF00 -> result_q=32'hF000 after one rising edge.
